uart_pkt_ctrl: RTL

UART_PKT_CTRL -- requirements
Module: uart_pkt_ctrl

---
 rtl/uart_pkt_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_pkt_ctrl.sv
// uart_pkt_ctrl: turns a UART byte stream into framed packets.
//   Frame: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK, where
//   CHK = (CMD + LEN + payload bytes) mod 256.
//   Payload bytes are written to an external buffer as they arrive.
//   Good packets pulse pkt_valid. Bad checksum, over-long LEN or a
//   line gap mid-packet pulse pkt_err and set err_code.
//
// Optional feature: define UART_PKT_STATS_EN to enable the saturating
// stat_good/stat_err counters. When it is undefined, both read 0.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   rx_data         received byte
//   rx_data_ready   strobe, rx_data valid
//   rx_endofpacket  strobe, line gap seen by the receiver
//   wr_en/wr_addr/wr_data   payload buffer write port
//   pkt_valid/pkt_cmd/pkt_len   good-packet strobe and its header
//   pkt_err/err_code  reject strobe and cause (1 chk, 2 len, 3 truncated)
//   busy            high while a packet is in progress
//   stat_good/stat_err   packet counters
module uart_pkt_ctrl #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned MAX_LEN   = 64,
   parameter int unsigned ADDR_W    = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_data_ready,
   input  logic              rx_endofpacket,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              pkt_valid,
   output logic [7:0]        pkt_cmd,
   output logic [7:0]        pkt_len,
   output logic              pkt_err,
   output logic [1:0]        err_code,
   output logic              busy,
   output logic [15:0]       stat_good,
   output logic [15:0]       stat_err
);

   localparam logic [7:0] MaxLen = 8'(MAX_LEN);

   localparam logic [1:0] ErrChk   = 2'd1;
   localparam logic [1:0] ErrLen   = 2'd2;
   localparam logic [1:0] ErrTrunc = 2'd3;

   typedef enum logic [2:0] {StIdle, StCmd, StLen, StData, StChk} state_t;

   state_t     state;
   logic [7:0] sum;
   logic [7:0] cmd;
   logic [7:0] len;
   logic [7:0] idx;

   assign busy = (state != StIdle);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         sum       <= 8'd0;
         cmd       <= 8'd0;
         len       <= 8'd0;
         idx       <= 8'd0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= 8'd0;
         pkt_valid <= 1'b0;
         pkt_cmd   <= 8'd0;
         pkt_len   <= 8'd0;
         pkt_err   <= 1'b0;
         err_code  <= 2'd0;
      end else begin
         wr_en     <= 1'b0;
         pkt_valid <= 1'b0;
         pkt_err   <= 1'b0;
         // A byte strobe wins over a simultaneous line-gap strobe.
         if (rx_data_ready) begin
            unique case (state)
               StIdle: begin
                  if (rx_data == SYNC_BYTE) state <= StCmd;
               end
               StCmd: begin
                  cmd   <= rx_data;
                  sum   <= rx_data;
                  state <= StLen;
               end
               StLen: begin
                  len <= rx_data;
                  sum <= sum + rx_data;
                  idx <= 8'd0;
                  if (rx_data > MaxLen) begin
                     pkt_err  <= 1'b1;
                     err_code <= ErrLen;
                     state    <= StIdle;
                  end else if (rx_data == 8'd0) begin
                     state <= StChk;
                  end else begin
                     state <= StData;
                  end
               end
               StData: begin
                  wr_en   <= 1'b1;
                  wr_addr <= idx[ADDR_W-1:0];
                  wr_data <= rx_data;
                  sum     <= sum + rx_data;
                  idx     <= idx + 8'd1;
                  if (idx == len - 8'd1) state <= StChk;
               end
               StChk: begin
                  if (rx_data == sum) begin
                     pkt_valid <= 1'b1;
                     pkt_cmd   <= cmd;
                     pkt_len   <= len;
                  end else begin
                     pkt_err  <= 1'b1;
                     err_code <= ErrChk;
                  end
                  state <= StIdle;
               end
               default: state <= StIdle;
            endcase
         end else if (rx_endofpacket && state != StIdle) begin
            pkt_err  <= 1'b1;
            err_code <= ErrTrunc;
            state    <= StIdle;
         end
      end
   end

`ifdef UART_PKT_STATS_EN
   // Counters follow the registered strobes, so they lag them by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_good <= 16'd0;
         stat_err  <= 16'd0;
      end else begin
         if (pkt_valid && stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
         if (pkt_err && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end
   end
`else
   assign stat_good = 16'd0;
   assign stat_err  = 16'd0;
`endif

endmodule
